// File: rtl/alu_bus_pkg.sv
// Shared definitions for the 8-bit serial-operand ALU bus: op codes, host FSM states
// and per-operation byte counts.
package alu_bus_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND0,
        SEND1,
        SEND2,
        WAIT,
        RECV1,
        RESP
    } host_state_t;

    // Division carries a 16-bit dividend, so it needs one extra operand byte.
    function automatic logic [1:0] n_operand_bytes(input logic [1:0] op);
        return (op == ALU_DIV) ? 2'd3 : 2'd2;
    endfunction

    // Multiply and divide return a second result byte the cycle after END.
    function automatic logic [1:0] n_result_bytes(input logic [1:0] op);
        return (op == ALU_MUL || op == ALU_DIV) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/alu_host_watchdog.sv
// Wait-phase watchdog: up-counter with clear and enable, flagging the last allowed cycle.
module alu_host_watchdog #(
    parameter int LIMIT = 64,
    parameter int TW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == TW'(LIMIT - 1));

endmodule

// File: rtl/alu_host_driver.sv
// Host-side initiator for the serial-operand ALU bus: takes one request, serialises the
// operands onto inbus, collects the result bytes and returns a single 16-bit response.
module alu_host_driver
    import alu_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [7:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        BEGIN,
    output logic [1:0]  op_code,
    output logic [7:0]  inbus,
    input  logic [7:0]  outbus,
    input  logic        END
);

    host_state_t state_reg, state_next;

    logic [1:0]  op_reg;
    logic [15:0] a_reg;
    logic [7:0]  b_reg;
    logic [7:0]  byte0_reg;
    logic        proto_err_reg;

    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic [15:0] rsp_data_reg, rsp_data_next;
    logic        rsp_err_reg, rsp_err_next;
    logic        begin_reg;
    logic [1:0]  op_code_reg, op_code_next;
    logic [7:0]  inbus_reg, inbus_next;

    logic        wd_expired;
    logic        in_send;

    alu_host_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .TW    (TW)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_reg != WAIT),
        .enable  (state_reg == WAIT),
        .expired (wd_expired)
    );

    assign in_send = (state_reg == START) || (state_reg == SEND0) ||
                     (state_reg == SEND1) || (state_reg == SEND2);

    always_comb begin
        state_next    = state_reg;
        rsp_data_next = rsp_data_reg;
        rsp_err_next  = rsp_err_reg;
        unique case (state_reg)
            IDLE:  if (req_valid && req_ready_reg) state_next = START;
            START: state_next = SEND0;
            SEND0: state_next = SEND1;
            SEND1: state_next = (n_operand_bytes(op_reg) == 2'd3) ? SEND2 : WAIT;
            SEND2: state_next = WAIT;
            WAIT: begin
                // A real END wins over an expiring watchdog in the same cycle.
                if (END) begin
                    if (n_result_bytes(op_reg) == 2'd1) begin
                        state_next    = RESP;
                        rsp_data_next = {8'h00, outbus};
                        rsp_err_next  = proto_err_reg;
                    end else begin
                        state_next = RECV1;
                    end
                end else if (wd_expired) begin
                    state_next    = RESP;
                    rsp_data_next = 16'h0000;
                    rsp_err_next  = 1'b1;
                end
            end
            RECV1: begin
                state_next    = RESP;
                rsp_data_next = {byte0_reg, outbus};
                rsp_err_next  = proto_err_reg;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next   = IDLE;
                    rsp_err_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        inbus_next = 8'h00;
        case (state_next)
            SEND0:   inbus_next = (op_reg == ALU_DIV) ? a_reg[15:8] : a_reg[7:0];
            SEND1:   inbus_next = (op_reg == ALU_DIV) ? a_reg[7:0]  : b_reg;
            SEND2:   inbus_next = b_reg;
            default: inbus_next = 8'h00;
        endcase
        if (state_next == IDLE) begin
            op_code_next = ALU_ADD;
        end else if (state_reg == IDLE) begin
            op_code_next = req_op;
        end else begin
            op_code_next = op_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            op_reg        <= ALU_ADD;
            a_reg         <= 16'h0000;
            b_reg         <= 8'h00;
            byte0_reg     <= 8'h00;
            proto_err_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 16'h0000;
            rsp_err_reg   <= 1'b0;
            begin_reg     <= 1'b0;
            op_code_reg   <= ALU_ADD;
            inbus_reg     <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid && req_ready_reg) begin
                op_reg <= req_op;
                a_reg  <= req_a;
                b_reg  <= req_b;
            end
            if (state_reg == WAIT && END) begin
                byte0_reg <= outbus;
            end
            if (in_send && END) begin
                proto_err_reg <= 1'b1;
            end else if (state_reg == RESP && rsp_ready) begin
                proto_err_reg <= 1'b0;
            end
            req_ready_reg <= (state_next == IDLE);
            rsp_valid_reg <= (state_next == RESP);
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
            begin_reg     <= (state_next == START);
            op_code_reg   <= op_code_next;
            inbus_reg     <= inbus_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign BEGIN     = begin_reg;
    assign op_code   = op_code_reg;
    assign inbus     = inbus_reg;

endmodule

// File: tb/tb_alu_host_driver.sv
// Bench for alu_host_driver: directed requests against a behavioural ALU, with a
// transaction-timeline scoreboard checking every output on every cycle.
module tb_alu_host_driver;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_a = 16'h0000;
    logic [7:0]  req_b = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        alu_begin;
    logic [1:0]  op_code;
    logic [7:0]  inbus;
    logic [7:0]  outbus = 8'h00;
    logic        alu_end;
    logic        alu_end_drv = 1'b0;
    logic        stim_end = 1'b0;

    bit alu_silent = 1'b0;
    int alu_lat = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    assign alu_end = alu_end_drv | stim_end;

    alu_host_driver #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .BEGIN     (alu_begin),
        .op_code   (op_code),
        .inbus     (inbus),
        .outbus    (outbus),
        .END       (alu_end)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic meaning of each request, straight from the operation definitions.
    function automatic logic [15:0] expect_data(input logic [1:0] op, input logic [15:0] a,
                                                input logic [7:0] b);
        int ia, ib, x;
        ia = int'(a);
        ib = int'(b);
        case (op)
            2'b00:   x = ((ia % 256) + ib) % 256;
            2'b01:   x = ((ia % 256) - ib + 256) % 256;
            2'b10:   x = (ia % 256) * ib;
            default: x = (ia / ib) * 256 + (ia % ib);
        endcase
        return 16'(x);
    endfunction

    // Behavioural ALU: collects operand bytes after BEGIN, answers with END after alu_lat.
    initial begin : alu_model
        logic [1:0]  op;
        logic [7:0]  rx [3];
        logic [15:0] p;
        logic [7:0]  r0, r1;
        int          nbytes;
        forever begin
            @(negedge clk);
            if (alu_begin === 1'b1) begin
                op = op_code;
                nbytes = (op == 2'b11) ? 3 : 2;
                for (int i = 0; i < nbytes; i++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    rx[i] = inbus;
                end
                r1 = 8'h00;
                case (op)
                    2'b00: r0 = rx[0] + rx[1];
                    2'b01: r0 = rx[0] - rx[1];
                    2'b10: begin
                        p  = 16'(rx[0]) * 16'(rx[1]);
                        r0 = p[15:8];
                        r1 = p[7:0];
                    end
                    default: begin
                        p  = {rx[0], rx[1]};
                        r0 = 8'(p / 16'(rx[2]));
                        r1 = 8'(p % 16'(rx[2]));
                    end
                endcase
                @(posedge clk); #1;
                if (!alu_silent) begin
                    repeat (alu_lat) begin @(posedge clk); #1; end
                    alu_end_drv = 1'b1;
                    outbus = r0;
                    @(posedge clk); #1;
                    alu_end_drv = 1'b0;
                    outbus = r1;
                    @(posedge clk); #1;
                    outbus = 8'h00;
                end
            end
        end
    end

    // Scoreboard: a per-transaction timeline (accept cycle, operand window, END/timeout
    // cycle, handshake) from which every output is predicted each cycle.
    initial begin : scoreboard
        bit          busy, have_rsp, m_timeout, m_proto;
        int          acc_c, wait_start, rsp_c, nb, n_txn;
        logic [7:0]  xb [3];
        logic [1:0]  m_op;
        logic [15:0] m_a;
        logic [7:0]  m_b;
        logic [7:0]  exp_in;
        logic        exp_valid;
        busy = 0; have_rsp = 0; m_timeout = 0; m_proto = 0;
        acc_c = 0; wait_start = 0; rsp_c = 0; nb = 0; n_txn = 0;
        m_op = 2'b00; m_a = 16'h0000; m_b = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset !== 1'b1) begin
                busy = 0;
                check("rst_req_ready", 32'(req_ready), 32'd1);
                check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                check("rst_rsp_data", 32'(rsp_data), 32'd0);
                check("rst_rsp_err", 32'(rsp_err), 32'd0);
                check("rst_begin", 32'(alu_begin), 32'd0);
                check("rst_op_code", 32'(op_code), 32'd0);
                check("rst_inbus", 32'(inbus), 32'd0);
            end else begin
                exp_in = 8'h00;
                if (busy && cyc >= acc_c + 2 && cyc < acc_c + 2 + nb) exp_in = xb[cyc - acc_c - 2];
                exp_valid = busy && have_rsp && (cyc >= rsp_c);
                check("req_ready", 32'(req_ready), 32'(!busy));
                check("begin", 32'(alu_begin), 32'(busy && cyc == acc_c + 1));
                check("inbus", 32'(inbus), 32'(exp_in));
                check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
                if (busy) check("op_code", 32'(op_code), 32'(m_op));
                if (exp_valid) begin
                    check("rsp_data", 32'(rsp_data),
                          32'(m_timeout ? 16'h0000 : expect_data(m_op, m_a, m_b)));
                    check("rsp_err", 32'(rsp_err), 32'(m_timeout || m_proto));
                end
                if (busy) begin
                    if (exp_valid) begin
                        if (rsp_ready) begin
                            n_txn++;
                            $display("txn %0d: op=%0d a=%04h b=%02h -> data=%04h err=%0d",
                                     n_txn, m_op, m_a, m_b, rsp_data, rsp_err);
                            busy = 0;
                        end
                    end else if (!have_rsp) begin
                        if (alu_end && cyc < wait_start) begin
                            m_proto = 1;
                        end else if (cyc >= wait_start) begin
                            if (alu_end) begin
                                have_rsp = 1;
                                rsp_c = cyc + ((m_op[1]) ? 2 : 1);
                            end else if (cyc == wait_start + T - 1) begin
                                have_rsp = 1;
                                m_timeout = 1;
                                rsp_c = cyc + 1;
                            end
                        end
                    end
                end else if (req_valid) begin
                    busy = 1; have_rsp = 0; m_timeout = 0; m_proto = 0;
                    acc_c = cyc;
                    m_op = req_op; m_a = req_a; m_b = req_b;
                    if (req_op == 2'b11) begin
                        nb = 3; xb[0] = req_a[15:8]; xb[1] = req_a[7:0]; xb[2] = req_b;
                    end else begin
                        nb = 2; xb[0] = req_a[7:0]; xb[1] = req_b; xb[2] = 8'h00;
                    end
                    wait_start = acc_c + 2 + nb;
                end
            end
        end
    end

    task automatic start_req(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
    endtask

    // Returns with the clock #1 past the accepting edge (START is the current cycle).
    task automatic finish_req(output int k);
        logic ok;
        k = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            ok = req_ready;
            k++;
            @(posedge clk); #1;
        end while (!ok && k < 100);
        req_valid = 1'b0;
        check("req_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_req(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
        int k;
        start_req(op, a, b);
        finish_req(k);
    endtask

    // Counts negedges until rsp_valid, checks literal result, then steps past the edge.
    task automatic wait_rsp(input string nm, input logic [15:0] ed, input logic ee, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid !== 1'b1 && n < 200);
        check({nm, "_valid"}, 32'(rsp_valid), 32'd1);
        check({nm, "_data"}, 32'(rsp_data), 32'(ed));
        check({nm, "_err"}, 32'(rsp_err), 32'(ee));
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        int n, k;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        alu_lat = 0;
        send_req(2'b00, 16'h0025, 8'h13);
        wait_rsp("add_25_13", 16'h0038, 1'b0, n);
        check("add_latency", 32'(n), 32'd5);

        alu_lat = 2;
        send_req(2'b01, 16'h0050, 8'h12);
        wait_rsp("sub_50_12", 16'h003E, 1'b0, n);

        alu_lat = 1;
        send_req(2'b00, 16'h00F0, 8'h20);
        wait_rsp("add_wrap", 16'h0010, 1'b0, n);

        alu_lat = 2;
        send_req(2'b10, 16'h0007, 8'h09);
        wait_rsp("mul_07_09", 16'h003F, 1'b0, n);
        check("mul_latency", 32'(n), 32'd8);

        alu_lat = 0;
        send_req(2'b10, 16'h00FF, 8'hFF);
        wait_rsp("mul_ff_ff", 16'hFE01, 1'b0, n);

        alu_lat = 1;
        send_req(2'b11, 16'h0064, 8'h07);
        wait_rsp("div_64_07", 16'h0E02, 1'b0, n);
        check("div_latency", 32'(n), 32'd8);

        alu_lat = 3;
        send_req(2'b11, 16'h03E8, 8'h0A);
        wait_rsp("div_3e8_0a", 16'h6400, 1'b0, n);

        // END while idle must be ignored; END during SEND0 flags the response.
        stim_end = 1'b1;
        @(posedge clk); #1;
        stim_end = 1'b0;
        @(posedge clk); #1;
        alu_lat = 0;
        send_req(2'b00, 16'h0001, 8'h02);
        @(posedge clk); #1;
        stim_end = 1'b1;
        @(posedge clk); #1;
        stim_end = 1'b0;
        wait_rsp("proto_err", 16'h0003, 1'b1, n);

        alu_silent = 1'b1;
        send_req(2'b00, 16'h0011, 8'h22);
        wait_rsp("timeout", 16'h0000, 1'b1, n);
        check("timeout_latency", 32'(n), 32'd20);
        alu_silent = 1'b0;

        // Backpressure: response held while a new request waits.
        rsp_ready = 1'b0;
        send_req(2'b00, 16'h0005, 8'h06);
        wait_rsp("bp_first", 16'h000B, 1'b0, n);
        start_req(2'b01, 16'h0009, 8'h0A);
        repeat (4) begin
            @(negedge clk);
            check("bp_hold_data", 32'(rsp_data), 32'h000B);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        finish_req(k);
        check("bp_accept_spacing", 32'(k), 32'd2);
        wait_rsp("bp_second", 16'h00FF, 1'b0, n);

        // Reset during the WAIT phase of a multiply.
        alu_silent = 1'b1;
        send_req(2'b10, 16'h0007, 8'h09);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(negedge clk);
        check("midrst_begin", 32'(alu_begin), 32'd0);
        check("midrst_inbus", 32'(inbus), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        alu_silent = 1'b0;
        @(negedge clk);
        check("postrst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        send_req(2'b00, 16'h0025, 8'h13);
        wait_rsp("postrst_add", 16'h0038, 1'b0, n);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
